// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - F-stage next-PC selection, PC/F-D enables, halt/fault sequencing and fetch counter
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_DEPTH = 4096,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_f,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [31:0]      redir_target,
    input  logic             halt_req,
    output logic [31:0]      npc,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             halt_ack,
    output logic             fetch_fault,
    output logic [31:0]      fault_pc,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    // Upper bound is computed in 33 bits so a range ending at 2^32 cannot wrap to zero.
    localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + (33'(IM_DEPTH) * 33'd4);

    state_t            state_q, state_d;
    logic [31:0]       fault_pc_q, fault_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       cand;
    logic              cand_illegal;

    assign cand         = redir_valid ? redir_target : (pc_f + 32'd4);
    assign cand_illegal = (cand[1:0] != 2'b00) || (cand < RESET_PC) || ({1'b0, cand} >= PC_LIMIT);

    always_comb begin
        state_d    = state_q;
        fault_pc_d = fault_pc_q;
        pc_en      = 1'b0;
        fd_en      = 1'b1;
        fd_flush   = 1'b1;
        case (state_q)
            RUN: begin
                if (stall) begin
                    fd_en    = 1'b0;
                    fd_flush = 1'b0;
                end else if (cand_illegal) begin
                    fault_pc_d = cand;
                    state_d    = FAULT;
                end else if (redir_valid) begin
                    // Delay slot moves to D; a coincident halt waits for the next cycle.
                    pc_en    = 1'b1;
                    fd_flush = 1'b0;
                end else if (halt_req) begin
                    state_d = HALTED;
                end else begin
                    pc_en    = 1'b1;
                    fd_flush = 1'b0;
                end
            end
            HALTED: begin
                if (!halt_req) begin
                    state_d = RUN;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (reset) begin
            pc_en    = 1'b0;
            fd_en    = 1'b1;
            fd_flush = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        if ((state_q == RUN) && pc_en && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            fault_pc_q <= 32'd0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    assign npc         = cand;
    assign halt_ack    = (state_q == HALTED);
    assign fetch_fault = (state_q == FAULT);
    assign fault_pc    = fault_pc_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed vector bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        halt_req;

    logic [31:0] npc, fault_pc, fetch_count;
    logic        pc_en, fd_en, fd_flush, halt_ack, fetch_fault;

    logic [31:0] npc2, fault_pc2;
    logic [3:0]  fetch_count2;
    logic        pc_en2, fd_en2, fd_flush2, halt_ack2, fetch_fault2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .pc_f(pc_f), .stall(stall),
        .redir_valid(redir_valid), .redir_target(redir_target), .halt_req(halt_req),
        .npc(npc), .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
        .halt_ack(halt_ack), .fetch_fault(fetch_fault), .fault_pc(fault_pc),
        .fetch_count(fetch_count)
    );

    fetch_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .pc_f(pc_f), .stall(stall),
        .redir_valid(redir_valid), .redir_target(redir_target), .halt_req(halt_req),
        .npc(npc2), .pc_en(pc_en2), .fd_en(fd_en2), .fd_flush(fd_flush2),
        .halt_ack(halt_ack2), .fetch_fault(fetch_fault2), .fault_pc(fault_pc2),
        .fetch_count(fetch_count2)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        st;
        logic        rv;
        logic [31:0] tgt;
        logic        hr;
        logic [31:0] e_npc;
        logic        e_pe;
        logic        e_fe;
        logic        e_fl;
        logic        e_ack;
        logic        e_ff;
        logic [31:0] e_fpc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [31:0] pc, input logic st, input logic rv,
                       input logic [31:0] tgt, input logic hr, input logic [31:0] e_npc,
                       input logic e_pe, input logic e_fe, input logic e_fl, input logic e_ack,
                       input logic e_ff, input logic [31:0] e_fpc, input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.pc = pc; v.st = st; v.rv = rv; v.tgt = tgt; v.hr = hr;
        v.e_npc = e_npc; v.e_pe = e_pe; v.e_fe = e_fe; v.e_fl = e_fl;
        v.e_ack = e_ack; v.e_ff = e_ff; v.e_fpc = e_fpc; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [31:0] pc, input logic st,
                         input logic rv, input logic [31:0] tgt, input logic hr);
        reset = rst; pc_f = pc; stall = st; redir_valid = rv; redir_target = tgt; halt_req = hr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   rst pc            st rv tgt           hr  npc           pe fe fl ack ff fpc           cnt
        add(1, 32'h3000,     0, 0, 32'h0,      0, 32'h3004,     0, 1, 1, 0, 0, 32'h0,     0);
        add(0, 32'h3000,     0, 0, 32'h0,      0, 32'h3004,     1, 1, 0, 0, 0, 32'h0,     0);
        add(0, 32'h3004,     0, 0, 32'h0,      0, 32'h3008,     1, 1, 0, 0, 0, 32'h0,     1);
        add(0, 32'h3008,     0, 0, 32'h0,      0, 32'h300C,     1, 1, 0, 0, 0, 32'h0,     2);
        add(0, 32'h300C,     1, 0, 32'h0,      0, 32'h3010,     0, 0, 0, 0, 0, 32'h0,     3);
        add(0, 32'h300C,     1, 0, 32'h0,      0, 32'h3010,     0, 0, 0, 0, 0, 32'h0,     3);
        add(0, 32'h300C,     0, 0, 32'h0,      0, 32'h3010,     1, 1, 0, 0, 0, 32'h0,     3);
        add(0, 32'h3010,     0, 1, 32'h3100,   0, 32'h3100,     1, 1, 0, 0, 0, 32'h0,     4);
        add(0, 32'h3100,     1, 1, 32'h3200,   1, 32'h3200,     0, 0, 0, 0, 0, 32'h0,     5);
        add(0, 32'h3104,     0, 1, 32'h3100,   1, 32'h3100,     1, 1, 0, 0, 0, 32'h0,     5);
        add(0, 32'h3100,     0, 0, 32'h0,      1, 32'h3104,     0, 1, 1, 0, 0, 32'h0,     6);
        add(0, 32'h3100,     0, 0, 32'h0,      1, 32'h3104,     0, 1, 1, 1, 0, 32'h0,     6);
        add(0, 32'h3100,     1, 1, 32'h3000,   0, 32'h3000,     0, 1, 1, 1, 0, 32'h0,     6);
        add(0, 32'h3100,     0, 0, 32'h0,      0, 32'h3104,     1, 1, 0, 0, 0, 32'h0,     6);
        add(0, 32'h3104,     0, 1, 32'h2FFC,   0, 32'h2FFC,     0, 1, 1, 0, 0, 32'h0,     7);
        add(0, 32'h3104,     0, 0, 32'h0,      1, 32'h3108,     0, 1, 1, 0, 1, 32'h2FFC,  7);
        add(0, 32'h3104,     1, 0, 32'h0,      0, 32'h3108,     0, 1, 1, 0, 1, 32'h2FFC,  7);
        add(1, 32'h3104,     0, 0, 32'h0,      0, 32'h3108,     0, 1, 1, 0, 1, 32'h2FFC,  7);
        add(0, 32'h3000,     0, 0, 32'h0,      0, 32'h3004,     1, 1, 0, 0, 0, 32'h0,     0);
        add(0, 32'h3004,     0, 1, 32'h3102,   0, 32'h3102,     0, 1, 1, 0, 0, 32'h0,     1);
        add(0, 32'h3004,     0, 0, 32'h0,      0, 32'h3008,     0, 1, 1, 0, 1, 32'h3102,  1);
        add(1, 32'h3000,     0, 0, 32'h0,      0, 32'h3004,     0, 1, 1, 0, 1, 32'h3102,  1);
        add(0, 32'h6FF8,     0, 0, 32'h0,      0, 32'h6FFC,     1, 1, 0, 0, 0, 32'h0,     0);
        add(0, 32'h6FFC,     0, 0, 32'h0,      0, 32'h7000,     0, 1, 1, 0, 0, 32'h0,     1);
        add(0, 32'h6FFC,     0, 0, 32'h0,      0, 32'h7000,     0, 1, 1, 0, 1, 32'h7000,  1);
        add(1, 32'hFFFFFFFC, 0, 0, 32'h0,      0, 32'h0,        0, 1, 1, 0, 1, 32'h7000,  1);
        add(0, 32'hFFFFFFFC, 0, 0, 32'h0,      1, 32'h0,        0, 1, 1, 0, 0, 32'h0,     0);
        add(0, 32'h3000,     0, 0, 32'h0,      1, 32'h3004,     0, 1, 1, 0, 1, 32'h0,     0);
        add(1, 32'h3000,     0, 0, 32'h0,      0, 32'h3004,     0, 1, 1, 0, 1, 32'h0,     0);
        add(0, 32'h3000,     0, 0, 32'h0,      1, 32'h3004,     0, 1, 1, 0, 0, 32'h0,     0);
        add(0, 32'h3000,     0, 0, 32'h0,      1, 32'h3004,     0, 1, 1, 1, 0, 32'h0,     0);
        add(1, 32'h3000,     0, 0, 32'h0,      1, 32'h3004,     0, 1, 1, 1, 0, 32'h0,     0);
        add(0, 32'h3000,     0, 0, 32'h0,      0, 32'h3004,     1, 1, 0, 0, 0, 32'h0,     0);

        drive(1, 32'h3000, 0, 0, 32'h0, 0);
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].pc, vecs[i].st, vecs[i].rv, vecs[i].tgt, vecs[i].hr);
            #3;
            chk($sformatf("r%0d npc", i),         npc,                  vecs[i].e_npc);
            chk($sformatf("r%0d pc_en", i),       {31'd0, pc_en},       {31'd0, vecs[i].e_pe});
            chk($sformatf("r%0d fd_en", i),       {31'd0, fd_en},       {31'd0, vecs[i].e_fe});
            chk($sformatf("r%0d fd_flush", i),    {31'd0, fd_flush},    {31'd0, vecs[i].e_fl});
            chk($sformatf("r%0d halt_ack", i),    {31'd0, halt_ack},    {31'd0, vecs[i].e_ack});
            chk($sformatf("r%0d fetch_fault", i), {31'd0, fetch_fault}, {31'd0, vecs[i].e_ff});
            chk($sformatf("r%0d fault_pc", i),    fault_pc,             vecs[i].e_fpc);
            chk($sformatf("r%0d fetch_count", i), fetch_count,          vecs[i].e_cnt);
            next_cycle();
        end

        // Saturation: 20 accepted fetches on both instances.
        drive(1, 32'h3000, 0, 0, 32'h0, 0);
        next_cycle();
        for (int n = 0; n < 20; n++) begin
            drive(0, 32'h3000 + 32'(4 * n), 0, 0, 32'h0, 0);
            next_cycle();
            if (n == 14) chk("sat4 count at 15", {28'd0, fetch_count2}, 32'hF);
        end
        chk("sat4 count at 20", {28'd0, fetch_count2}, 32'hF);
        chk("count32 at 20", fetch_count, 32'd20);

        // Fault freeze: PC held for 10 cycles, then reset clears the fault.
        drive(0, 32'h3050, 0, 1, 32'h2FFC, 0);
        next_cycle();
        drive(0, 32'h3050, 0, 0, 32'h0, 0);
        for (int n = 0; n < 10; n++) begin
            #3;
            chk($sformatf("freeze%0d pc_en", n),       {31'd0, pc_en},       32'd0);
            chk($sformatf("freeze%0d fetch_fault", n), {31'd0, fetch_fault}, 32'd1);
            next_cycle();
        end
        chk("freeze fault_pc", fault_pc, 32'h2FFC);
        chk("freeze count", fetch_count, 32'd20);
        drive(1, 32'h3000, 0, 0, 32'h0, 0);
        next_cycle();
        drive(0, 32'h3000, 0, 0, 32'h0, 0);
        #3;
        chk("post-reset fetch_fault", {31'd0, fetch_fault}, 32'd0);
        chk("post-reset fault_pc", fault_pc, 32'h0);
        chk("post-reset pc_en", {31'd0, pc_en}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
